// File: rtl/ex_mem_skid_stage.sv
// rtl/ex_mem_skid_stage.sv - EX->MEM pipeline stage with 2-entry skid buffer, flush, forwarding tap and stall counter
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 synchronous kill of all held entries
//   EX_valid / EX_ready   upstream handshake (EX_ready is a flop)
//   EX_regwrite..EX_rd    upstream control bits and payload
//   MEM_valid / MEM_ready downstream handshake
//   MEM_regwrite..MEM_rd  head entry; control bits qualified by MEM_valid
//   fwd_valid/rd/data     forwarding tap for the EX hazard unit
//   stall_cnt             saturating count of back-pressured cycles
module ex_mem_skid_stage #(
  parameter int DATA_W = 19,
  parameter int RD_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              EX_valid,
  output logic              EX_ready,
  input  logic              EX_regwrite,
  input  logic              EX_memtoreg,
  input  logic              EX_memread,
  input  logic              EX_memwrite,
  input  logic [DATA_W-1:0] EX_out,
  input  logic [DATA_W-1:0] EX_wdata,
  input  logic [RD_W-1:0]   EX_rd,
  output logic              MEM_valid,
  input  logic              MEM_ready,
  output logic              MEM_regwrite,
  output logic              MEM_memtoreg,
  output logic              MEM_memread,
  output logic              MEM_memwrite,
  output logic [DATA_W-1:0] MEM_out,
  output logic [DATA_W-1:0] MEM_wdata,
  output logic [RD_W-1:0]   MEM_rd,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int ENT_W = 4 + 2 * DATA_W + RD_W;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t             state_q, state_d;
  logic               ready_q;
  logic [ENT_W-1:0]   main_q, skid_q, entry_in;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept, drain, stall;
  logic               load_main, load_skid, main_from_skid;
  logic               h_regwrite, h_memtoreg, h_memread, h_memwrite;

  assign entry_in = {EX_regwrite, EX_memtoreg, EX_memread, EX_memwrite, EX_out, EX_wdata, EX_rd};

  assign MEM_valid = (state_q != S_EMPTY);
  assign accept    = EX_valid & ready_q;
  assign drain     = MEM_valid & MEM_ready;
  assign stall     = MEM_valid & ~MEM_ready;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d   = S_ONE;
          load_main = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = S_TWO;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        // EX_ready is low here, so only a drain can move us.
        if (drain) begin
          state_d        = S_ONE;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // The counter follows the pre-edge stall condition regardless of flush.
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (flush) begin
        state_q <= S_EMPTY;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        ready_q <= (state_d != S_TWO);
        if (load_main) begin
          main_q <= entry_in;
        end else if (main_from_skid) begin
          main_q <= skid_q;
        end
        if (load_skid) begin
          skid_q <= entry_in;
        end
      end
    end
  end

  assign {h_regwrite, h_memtoreg, h_memread, h_memwrite, MEM_out, MEM_wdata, MEM_rd} = main_q;

  // Control bits are masked so an empty stage looks like a bubble downstream.
  assign MEM_regwrite = h_regwrite & MEM_valid;
  assign MEM_memtoreg = h_memtoreg & MEM_valid;
  assign MEM_memread  = h_memread  & MEM_valid;
  assign MEM_memwrite = h_memwrite & MEM_valid;

  assign fwd_valid = MEM_valid & MEM_regwrite & ~MEM_memtoreg;
  assign fwd_rd    = MEM_rd;
  assign fwd_data  = MEM_out;

  assign EX_ready  = ready_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb/tb_ex_mem_skid_stage.sv - self-checking bench for ex_mem_skid_stage
module tb_ex_mem_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, ex_valid, mem_ready;
  logic        ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite;
  logic [18:0] ex_out, ex_wdata;
  logic [2:0]  ex_rd;

  logic        ex_ready, mem_valid, mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite;
  logic [18:0] mem_out, mem_wdata, fwd_data;
  logic [2:0]  mem_rd, fwd_rd;
  logic        fwd_valid;
  logic [15:0] stall_cnt;

  logic        s_ex_ready, s_mem_valid, s_regwrite, s_memtoreg, s_memread, s_memwrite, s_fwd_valid;
  logic [18:0] s_out, s_wdata, s_fwd_data;
  logic [2:0]  s_rd, s_fwd_rd;
  logic [3:0]  stall_cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem_skid_stage #(.DATA_W(19), .RD_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .EX_valid(ex_valid), .EX_ready(ex_ready),
    .EX_regwrite(ex_regwrite), .EX_memtoreg(ex_memtoreg), .EX_memread(ex_memread),
    .EX_memwrite(ex_memwrite), .EX_out(ex_out), .EX_wdata(ex_wdata), .EX_rd(ex_rd),
    .MEM_valid(mem_valid), .MEM_ready(mem_ready), .MEM_regwrite(mem_regwrite),
    .MEM_memtoreg(mem_memtoreg), .MEM_memread(mem_memread), .MEM_memwrite(mem_memwrite),
    .MEM_out(mem_out), .MEM_wdata(mem_wdata), .MEM_rd(mem_rd), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .stall_cnt(stall_cnt)
  );

  ex_mem_skid_stage #(.DATA_W(19), .RD_W(3), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .EX_valid(ex_valid), .EX_ready(s_ex_ready),
    .EX_regwrite(ex_regwrite), .EX_memtoreg(ex_memtoreg), .EX_memread(ex_memread),
    .EX_memwrite(ex_memwrite), .EX_out(ex_out), .EX_wdata(ex_wdata), .EX_rd(ex_rd),
    .MEM_valid(s_mem_valid), .MEM_ready(mem_ready), .MEM_regwrite(s_regwrite),
    .MEM_memtoreg(s_memtoreg), .MEM_memread(s_memread), .MEM_memwrite(s_memwrite),
    .MEM_out(s_out), .MEM_wdata(s_wdata), .MEM_rd(s_rd), .fwd_valid(s_fwd_valid),
    .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data), .stall_cnt(stall_cnt4)
  );

  typedef struct {
    logic        rst_n, flush, ex_valid, mem_ready;
    logic [18:0] ex_out;
    logic        exp_valid, exp_ready;
    logic [18:0] exp_out;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic        rw, mtr, mr, mw;
    logic [18:0] out, wdata;
    logic [2:0]  rd;
  } ent_t;

  vec_t tbl [14];
  ent_t q[$];
  ent_t e;
  logic m_ready;
  int   m_cnt, m_cnt4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [18:0] o, input logic mr, input logic fl);
    ex_valid  = v;
    ex_out    = o;
    ex_wdata  = o + 19'd1;
    ex_rd     = o[2:0];
    mem_ready = mr;
    flush     = fl;
  endtask

  initial begin
    //          rst flush v  mr  ex_out     valid rdy exp_out   cnt
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 19'h55, 1'b0, 1'b1, 19'h0,  16'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 19'h55, 1'b0, 1'b1, 19'h0,  16'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 19'h1,  1'b1, 1'b1, 19'h1,  16'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 19'h2,  1'b1, 1'b1, 19'h2,  16'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 19'h3,  1'b1, 1'b1, 19'h3,  16'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 19'h4,  1'b1, 1'b1, 19'h4,  16'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 19'h0,  1'b0, 1'b1, 19'h0,  16'd0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 19'h10, 1'b1, 1'b1, 19'h10, 16'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 19'h20, 1'b1, 1'b0, 19'h10, 16'd1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 19'h30, 1'b1, 1'b0, 19'h10, 16'd2};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 19'h30, 1'b1, 1'b0, 19'h10, 16'd3};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 19'h30, 1'b1, 1'b1, 19'h20, 16'd3};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 19'h30, 1'b1, 1'b1, 19'h30, 16'd3};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 19'h0,  1'b0, 1'b1, 19'h0,  16'd3};

    ex_regwrite = 1'b1; ex_memtoreg = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b1;
    rst_n = 1'b0;
    drive(1'b0, 19'h0, 1'b0, 1'b0);

    // Reset, streaming and back-pressure vectors
    for (int i = 0; i < 14; i++) begin
      rst_n = tbl[i].rst_n;
      drive(tbl[i].ex_valid, tbl[i].ex_out, tbl[i].mem_ready, tbl[i].flush);
      tick();
      check($sformatf("vec%0d_valid", i), {31'b0, mem_valid}, {31'b0, tbl[i].exp_valid});
      check($sformatf("vec%0d_ready", i), {31'b0, ex_ready}, {31'b0, tbl[i].exp_ready});
      check($sformatf("vec%0d_memwrite", i), {31'b0, mem_memwrite}, {31'b0, tbl[i].exp_valid});
      check($sformatf("vec%0d_cnt", i), {16'b0, stall_cnt}, {16'b0, tbl[i].exp_cnt});
      if (tbl[i].exp_valid || !tbl[i].rst_n)
        check($sformatf("vec%0d_out", i), {13'b0, mem_out}, {13'b0, tbl[i].exp_out});
    end

    // Flush while holding two entries, with D offered in the same cycle
    drive(1'b1, 19'h10, 1'b0, 1'b0); tick();
    drive(1'b1, 19'h20, 1'b0, 1'b0); tick();
    check("flush_pre_ready", {31'b0, ex_ready}, 32'd0);
    drive(1'b1, 19'h40, 1'b0, 1'b1); tick();
    check("flush_valid", {31'b0, mem_valid}, 32'd0);
    check("flush_memwrite", {31'b0, mem_memwrite}, 32'd0);
    check("flush_ready", {31'b0, ex_ready}, 32'd1);
    drive(1'b0, 19'h0, 1'b1, 1'b0); tick();
    check("flush_no_d", {31'b0, mem_valid}, 32'd0);

    // Forwarding tap
    ex_memwrite = 1'b0;
    drive(1'b1, 19'h7FFFF, 1'b0, 1'b0); ex_rd = 3'd5; tick();
    check("fwd_valid", {31'b0, fwd_valid}, 32'd1);
    check("fwd_rd", {29'b0, fwd_rd}, 32'd5);
    check("fwd_data", {13'b0, fwd_data}, 32'h7FFFF);
    ex_memtoreg = 1'b1;
    drive(1'b1, 19'h7FFFF, 1'b1, 1'b0); ex_rd = 3'd5; tick();
    check("fwd_mtr_valid", {31'b0, fwd_valid}, 32'd0);
    check("fwd_mtr_head", {31'b0, mem_memtoreg}, 32'd1);
    drive(1'b0, 19'h0, 1'b1, 1'b0); tick();
    check("fwd_empty", {31'b0, mem_valid}, 32'd0);

    // Saturation of the narrow counter
    ex_memtoreg = 1'b0;
    rst_n = 1'b0; drive(1'b0, 19'h0, 1'b0, 1'b0); tick();
    rst_n = 1'b1; drive(1'b1, 19'h9, 1'b0, 1'b0); tick();
    drive(1'b0, 19'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("sat4_%0d", k), {28'b0, stall_cnt4}, (k < 15) ? k : 15);
      check($sformatf("sat16_%0d", k), {16'b0, stall_cnt}, k);
    end

    // Randomized run against a queue model
    q.delete(); m_ready = 1'b1; m_cnt = 0; m_cnt4 = 0;
    for (int i = 0; i < 600; i++) begin
      rst_n       = (i == 0) ? 1'b0 : ($urandom_range(63) != 0);
      flush       = ($urandom_range(15) == 0);
      mem_ready   = flush ? 1'b1 : 1'($urandom_range(1));
      ex_valid    = 1'($urandom_range(1));
      ex_regwrite = 1'($urandom_range(1));
      ex_memtoreg = 1'($urandom_range(1));
      ex_memread  = 1'($urandom_range(1));
      ex_memwrite = 1'($urandom_range(1));
      ex_out      = 19'($urandom);
      ex_wdata    = 19'($urandom);
      ex_rd       = 3'($urandom);
      e = '{ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite, ex_out, ex_wdata, ex_rd};
      if (!rst_n) begin
        q.delete(); m_ready = 1'b1; m_cnt = 0; m_cnt4 = 0;
      end else begin
        if (q.size() > 0 && !mem_ready) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt4 < 15) m_cnt4++;
        end
        if (flush) begin
          q.delete(); m_ready = 1'b1;
        end else begin
          logic acc;
          acc = ex_valid && m_ready;
          if (q.size() > 0 && mem_ready) void'(q.pop_front());
          if (acc) q.push_back(e);
          m_ready = (q.size() < 2);
        end
      end
      tick();
      check("rnd_valid", {31'b0, mem_valid}, {31'b0, q.size() > 0});
      check("rnd_ready", {31'b0, ex_ready}, {31'b0, m_ready});
      check("rnd_cnt", {16'b0, stall_cnt}, m_cnt);
      check("rnd_cnt4", {28'b0, stall_cnt4}, m_cnt4);
      if (q.size() > 0) begin
        check("rnd_out", {13'b0, mem_out}, {13'b0, q[0].out});
        check("rnd_wdata", {13'b0, mem_wdata}, {13'b0, q[0].wdata});
        check("rnd_rd", {29'b0, mem_rd}, {29'b0, q[0].rd});
        check("rnd_ctl", {28'b0, mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite},
              {28'b0, q[0].rw, q[0].mtr, q[0].mr, q[0].mw});
        check("rnd_fwd", {31'b0, fwd_valid}, {31'b0, q[0].rw & ~q[0].mtr});
      end else begin
        check("rnd_bubble", {28'b0, mem_regwrite, mem_memtoreg, mem_memread, mem_memwrite}, 32'd0);
        check("rnd_fwd_idle", {31'b0, fwd_valid}, 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
